// File: rtl/csr_pkg.sv
// csr_pkg: Zicsr funct3 encodings, FSM states and the read-only CSR address prefix.
package csr_pkg;
    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;
    localparam logic [1:0] RO_PREFIX = 2'b11;
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
    function automatic logic f3_illegal(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/csr_rmw_unit_if.sv
// csr_rmw_unit_if: request, CSR-file and response signals of the CSR read-modify-write unit.
interface csr_rmw_unit_if #(parameter int XLEN = 32, parameter int ADDR_W = 12);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_rs1_idx;
    logic [XLEN-1:0]   req_rs1_val;
    logic [4:0]        req_rd_idx;
    logic              csr_rd_en;
    logic [ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]   csr_rd_data;
    logic              csr_wr_en;
    logic [XLEN-1:0]   csr_wr_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [4:0]        resp_rd_idx;
    logic              resp_rd_we;
    logic [XLEN-1:0]   resp_rd_data;
    logic              resp_illegal;
    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_val, req_rd_idx, csr_rd_data, resp_ready,
        input  req_ready, csr_rd_en, csr_addr, csr_wr_en, csr_wr_data, resp_valid, resp_rd_idx, resp_rd_we,
               resp_rd_data, resp_illegal
    );
    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_val, req_rd_idx, csr_rd_data, resp_ready,
        output req_ready, csr_rd_en, csr_addr, csr_wr_en, csr_wr_data, resp_valid, resp_rd_idx, resp_rd_we,
               resp_rd_data, resp_illegal
    );
endinterface

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: bitwise new-value computation for W/S/C plus whether the op really writes.
module csr_rmw_alu import csr_pkg::*; #(parameter int XLEN = 32) (
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] opnd,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] new_val,
    output logic            wr_q
);
    always_comb begin
        wr_q    = funct3[1:0] == CSRRW[1:0] || rs1_idx != 5'd0;
        new_val = funct3[1:0] == CSRRW[1:0] ? opnd :
                  funct3[1:0] == CSRRS[1:0] ? old | opnd : old & ~opnd;
    end
endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: Zicsr execute sequencer (read, modify, write back, respond), one op in flight.
// Optional read-only CSR write check enabled by defining CSR_RO_CHECK_EN.
module csr_rmw_unit import csr_pkg::*; #(parameter int XLEN = 32, parameter int ADDR_W = 12) (
    input logic           clk,
    input logic           reset,
    csr_rmw_unit_if.slave bus
);
    state_t            state, nxt;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        rs1, rd;
    logic [XLEN-1:0]   opnd, old, new_q, new_val;
    logic              ill, wr_q, ro_viol, skip_rd, req_skip;

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .old(bus.csr_rd_data), .opnd(opnd), .funct3(f3), .rs1_idx(rs1), .new_val(new_val), .wr_q(wr_q)
    );

    assign skip_rd  = f3[1:0] == CSRRW[1:0] && rd == 5'd0;
    assign req_skip = bus.req_funct3[1:0] == CSRRW[1:0] && bus.req_rd_idx == 5'd0;
`ifdef CSR_RO_CHECK_EN
    assign ro_viol = wr_q && addr[ADDR_W-1 -: 2] == RO_PREFIX;
`else
    assign ro_viol = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            f3    <= '0;
            addr  <= '0;
            rs1   <= '0;
            rd    <= '0;
            opnd  <= '0;
            old   <= '0;
            new_q <= '0;
            ill   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.req_valid) begin
                f3    <= bus.req_funct3;
                addr  <= bus.req_addr;
                rs1   <= bus.req_rs1_idx;
                rd    <= bus.req_rd_idx;
                opnd  <= bus.req_funct3[2] ? XLEN'(bus.req_rs1_idx) : bus.req_rs1_val;
                ill   <= f3_illegal(bus.req_funct3);
                old   <= '0;
            end
            if (state == WAIT) begin
                old   <= skip_rd ? '0 : bus.csr_rd_data;
                new_q <= new_val;
                ill   <= ro_viol;
            end
        end

    // Read-skipping writes still pass through WAIT (without a read strobe) so they finish one cycle early, not two.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !bus.req_valid ? IDLE : f3_illegal(bus.req_funct3) ? RESP : req_skip ? WAIT : READ;
            READ:    nxt = WAIT;
            WAIT:    nxt = wr_q && !ro_viol ? WRITE : RESP;
            WRITE:   nxt = RESP;
            RESP:    nxt = bus.resp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = state == IDLE;
        bus.csr_rd_en    = state == READ;
        bus.csr_wr_en    = state == WRITE;
        bus.csr_addr     = state == READ || state == WRITE ? addr : '0;
        bus.csr_wr_data  = state == WRITE ? new_q : '0;
        bus.resp_valid   = state == RESP;
        bus.resp_rd_idx  = state == RESP ? rd : '0;
        bus.resp_rd_we   = state == RESP && rd != 5'd0 && !ill;
        bus.resp_rd_data = state == RESP ? old : '0;
        bus.resp_illegal = state == RESP && ill;
    end
endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb_csr_rmw_unit: directed self-checking bench for csr_rmw_unit with a registered-read CSR file model.
module tb_csr_rmw_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] file_val = '0;
    int rd_c, wr_c, resp_c;
    logic [11:0] rd_addr, wr_addr;
    logic [31:0] wr_data, r_data;
    logic [4:0] r_idx;
    logic r_we, r_ill, overlap;

    csr_rmw_unit_if #(.XLEN(32), .ADDR_W(12)) bus ();
    csr_rmw_unit #(.XLEN(32), .ADDR_W(12)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.csr_rd_en) bus.csr_rd_data <= file_val;

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] val, input logic [4:0] rd, input logic [31:0] fv);
        file_val = fv;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_addr = a; bus.req_rs1_idx = idx;
        bus.req_rs1_val = val; bus.req_rd_idx = rd; bus.resp_ready = 1'b1;
        rd_c = -1; wr_c = -1; resp_c = -1; overlap = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 8 && resp_c < 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.csr_rd_en && bus.csr_wr_en) overlap = 1'b1;
            if (!bus.csr_rd_en && !bus.csr_wr_en && bus.csr_addr != 12'h0) overlap = 1'b1;
            if (bus.csr_rd_en) begin rd_c = c; rd_addr = bus.csr_addr; end
            if (bus.csr_wr_en) begin wr_c = c; wr_addr = bus.csr_addr; wr_data = bus.csr_wr_data; end
            if (bus.resp_valid) begin
                resp_c = c; r_idx = bus.resp_rd_idx; r_we = bus.resp_rd_we;
                r_data = bus.resp_rd_data; r_ill = bus.resp_illegal;
            end
        end
        checks++; if (resp_c < 0) begin errors++; $display("FAIL resp_timeout: got no resp_valid want one within 8 cycles"); end
        checks++; if (overlap) begin errors++; $display("FAIL strobe_rules: got overlap/stray addr want none"); end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_rs1_idx = '0;
        bus.req_rs1_val = '0; bus.req_rd_idx = '0; bus.resp_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.req_ready, bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 100000", {bus.req_ready, bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal}); end
        checks++; if ({bus.csr_addr, bus.csr_wr_data, bus.resp_rd_idx, bus.resp_rd_data} !== 81'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {bus.csr_addr, bus.csr_wr_data, bus.resp_rd_idx, bus.resp_rd_data}); end
        reset = 1'b1;
    endtask

    task automatic test_csrrs();
        run_op(3'b010, 12'h304, 5'd3, 32'h80, 5'd5, 32'h8);
        checks++; if (rd_c !== 1 || rd_addr !== 12'h304) begin errors++; $display("FAIL rs_read: got cyc %0d addr %h want 1 304", rd_c, rd_addr); end
        checks++; if (wr_c !== 3 || wr_data !== 32'h88 || wr_addr !== 12'h304) begin errors++; $display("FAIL rs_write: got cyc %0d data %h addr %h want 3 88 304", wr_c, wr_data, wr_addr); end
        checks++; if (resp_c !== 4) begin errors++; $display("FAIL rs_latency: got %0d want 4", resp_c); end
        checks++; if ({r_we, r_ill, r_idx, r_data} !== {1'b1, 1'b0, 5'd5, 32'h8}) begin errors++; $display("FAIL rs_resp: got we %b ill %b idx %0d data %h want 1 0 5 8", r_we, r_ill, r_idx, r_data); end
    endtask

    task automatic test_csrrci();
        run_op(3'b111, 12'h344, 5'h0F, 32'h1234_5678, 5'd7, 32'hFF);
        checks++; if (wr_c !== 3 || wr_data !== 32'hF0) begin errors++; $display("FAIL rci_write: got cyc %0d data %h want 3 f0", wr_c, wr_data); end
        checks++; if ({r_we, r_idx, r_data} !== {1'b1, 5'd7, 32'hFF}) begin errors++; $display("FAIL rci_resp: got we %b idx %0d data %h want 1 7 ff", r_we, r_idx, r_data); end
    endtask

    task automatic test_csrrw_rd0();
        run_op(3'b001, 12'h340, 5'd9, 32'hDEAD_BEEF, 5'd0, 32'h55);
        checks++; if (rd_c !== -1) begin errors++; $display("FAIL rw0_noread: got rd cyc %0d want none", rd_c); end
        checks++; if (wr_c !== 2 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw0_write: got cyc %0d data %h want 2 deadbeef", wr_c, wr_data); end
        checks++; if (resp_c !== 3 || r_we !== 1'b0 || r_data !== 32'h0) begin errors++; $display("FAIL rw0_resp: got cyc %0d we %b data %h want 3 0 0", resp_c, r_we, r_data); end
    endtask

    task automatic test_csrrs_zero();
        run_op(3'b010, 12'h300, 5'd0, 32'hFFFF, 5'd4, 32'h1234);
        checks++; if (rd_c !== 1 || wr_c !== -1) begin errors++; $display("FAIL rs0_strobes: got rd %0d wr %0d want 1 none", rd_c, wr_c); end
        checks++; if (resp_c !== 3 || r_we !== 1'b1 || r_data !== 32'h1234) begin errors++; $display("FAIL rs0_resp: got cyc %0d we %b data %h want 3 1 1234", resp_c, r_we, r_data); end
    endtask

    task automatic test_other_forms();
        run_op(3'b101, 12'h305, 5'h1F, 32'hFFFF_FFFF, 5'd2, 32'hABCD);
        checks++; if (wr_data !== 32'h1F || r_data !== 32'hABCD || wr_c !== 3) begin errors++; $display("FAIL rwi: got wr %h old %h cyc %0d want 1f abcd 3", wr_data, r_data, wr_c); end
        run_op(3'b011, 12'h306, 5'd8, 32'h0F0F, 5'd1, 32'hFFFF);
        checks++; if (wr_data !== 32'hF0F0 || r_data !== 32'hFFFF) begin errors++; $display("FAIL rc: got wr %h old %h want f0f0 ffff", wr_data, r_data); end
        run_op(3'b110, 12'h307, 5'h10, 32'h0, 5'd3, 32'h8000_0001);
        checks++; if (wr_data !== 32'h8000_0011) begin errors++; $display("FAIL rsi: got wr %h want 80000011", wr_data); end
    endtask

    task automatic test_illegal();
        run_op(3'b100, 12'h304, 5'd3, 32'h1, 5'd6, 32'h99);
        checks++; if (rd_c !== -1 || wr_c !== -1) begin errors++; $display("FAIL ill4_strobes: got rd %0d wr %0d want none", rd_c, wr_c); end
        checks++; if ({r_ill, r_we, r_data} !== {1'b1, 1'b0, 32'h0} || resp_c !== 1) begin errors++; $display("FAIL ill4_resp: got ill %b we %b data %h cyc %0d want 1 0 0 1", r_ill, r_we, r_data, resp_c); end
        run_op(3'b000, 12'h304, 5'd3, 32'h1, 5'd6, 32'h99);
        checks++; if ({r_ill, r_we} !== 2'b10 || wr_c !== -1) begin errors++; $display("FAIL ill0: got ill %b we %b wr %0d want 1 0 none", r_ill, r_we, wr_c); end
    endtask

    task automatic test_ro_space();
        run_op(3'b001, 12'hC00, 5'd4, 32'hAAAA, 5'd3, 32'h77);
`ifdef CSR_RO_CHECK_EN
        checks++; if ({r_ill, r_we} !== 2'b10 || wr_c !== -1 || rd_c !== 1) begin errors++; $display("FAIL ro_block: got ill %b we %b wr %0d rd %0d want 1 0 none 1", r_ill, r_we, wr_c, rd_c); end
        run_op(3'b010, 12'hC01, 5'd0, 32'h0, 5'd3, 32'h42);
        checks++; if ({r_ill, r_we, r_data} !== {1'b0, 1'b1, 32'h42}) begin errors++; $display("FAIL ro_read_ok: got ill %b we %b data %h want 0 1 42", r_ill, r_we, r_data); end
`else
        checks++; if ({r_ill, r_we} !== 2'b01 || wr_c !== 3 || wr_data !== 32'hAAAA) begin errors++; $display("FAIL ro_open: got ill %b we %b wr %0d data %h want 0 1 3 aaaa", r_ill, r_we, wr_c, wr_data); end
`endif
        checks++; if (r_data !== 32'h77) begin errors++; $display("FAIL ro_old: got %h want 77", r_data); end
    endtask

    task automatic test_stall_reset();
        bit seen;
        file_val = 32'h11;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 12'h305; bus.req_rs1_idx = 5'd1;
        bus.req_rs1_val = 32'h100; bus.req_rd_idx = 5'd9; bus.resp_ready = 1'b0;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            seen = bus.resp_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_timeout: got no resp_valid want one"); end
        for (int c = 0; c < 3; c++) begin
            checks++; if ({bus.resp_valid, bus.req_ready, bus.resp_rd_we, bus.resp_illegal, bus.resp_rd_idx, bus.resp_rd_data} !== {4'b1010, 5'd9, 32'h11}) begin
                errors++; $display("FAIL stall_hold%0d: got v %b rdy %b we %b ill %b idx %0d data %h want 1 0 1 0 9 11", c, bus.resp_valid, bus.req_ready, bus.resp_rd_we, bus.resp_illegal, bus.resp_rd_idx, bus.resp_rd_data); end
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.req_ready, bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal} !== 6'b100000 ||
                      {bus.csr_addr, bus.csr_wr_data, bus.resp_rd_idx, bus.resp_rd_data} !== 81'h0) begin
            errors++; $display("FAIL midreset: got ctrl %b data %h want 100000 0", {bus.req_ready, bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.resp_rd_we, bus.resp_illegal}, {bus.csr_addr, bus.csr_wr_data, bus.resp_rd_idx, bus.resp_rd_data}); end
        @(negedge clk);
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.req_ready} !== 4'b0001) begin errors++; $display("FAIL post_reset: got %b want 0001", {bus.csr_rd_en, bus.csr_wr_en, bus.resp_valid, bus.req_ready}); end
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'b001, 12'h341, 5'd5, 32'h1357_9BDF, 5'd10, 32'h2468);
        checks++; if (wr_data !== 32'h1357_9BDF || r_data !== 32'h2468 || resp_c !== 4) begin errors++; $display("FAIL b2b_first: got wr %h old %h cyc %0d want 13579bdf 2468 4", wr_data, r_data, resp_c); end
        run_op(3'b011, 12'h341, 5'd5, 32'h0000_00FF, 5'd11, 32'h1357_9BDF);
        checks++; if (wr_data !== 32'h1357_9B00 || r_idx !== 5'd11) begin errors++; $display("FAIL b2b_second: got wr %h idx %0d want 13579b00 11", wr_data, r_idx); end
    endtask

    initial begin
        test_reset();
        test_csrrs();
        test_csrrci();
        test_csrrw_rd0();
        test_csrrs_zero();
        test_other_forms();
        test_illegal();
        test_ro_space();
        test_stall_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
